mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port program/data memory of the simple CPU between three requesters:
//  the external program loader (used while the CPU sits in its reset/wait-for-start state),
//  the data load/store path and the instruction fetch path.
//  Accepts at most one access at a time and drives the memory with a fixed read latency.
//  Returns read data and a one-cycle ack to the winning requester.
// PARAMETERS
//  ADDR_W      8   memory address width
//  DATA_W      8   memory data width
//  MEM_LAT     1   cycles from mem_en to valid mem_rdata (>=1)
//  MAX_CONSEC  4   max back-to-back grants to one requester while another is pending (>=1)
// PORTS
//  clk        in   1        clock, all state updates on rising edge
//  rst        in   1        synchronous reset, active-high
//  req_i      in   3        request per requester: [0]=loader, [1]=data, [2]=fetch
//  we_i       in   3        write enable per requester
//  addr0_i    in   ADDR_W   loader address (addr1_i/addr2_i: data, fetch; same width)
//  wdata0_i   in   DATA_W   loader write data (wdata1_i/wdata2_i likewise)
//  ack_o      out  3        one-hot, one-cycle completion pulse to the granted requester
//  rdata_o    out  DATA_W   registered read data, valid in the ack cycle
//  busy_o     out  1        high in every state except IDLE
//  mem_en     out  1        memory access strobe, exactly one cycle per access
//  mem_we     out  1        memory write, qualifies mem_en
//  mem_addr   out  ADDR_W   memory address (held from ISSUE until ACK)
//  mem_wdata  out  DATA_W   memory write data (held from ISSUE until ACK)
//  mem_rdata  in   DATA_W   memory read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  - Reset: state=IDLE; ack_o, mem_en, mem_we, busy_o = 0; rdata_o, mem_addr, mem_wdata = 0;
//    lat counter=0, consec counter=0, last-grant=none. rst wins over every other event.
//  - FSM: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
//    IDLE:  if any req_i: pick winner, latch its addr/we/wdata into mem_* regs -> ISSUE;
//           else stay.
//    ISSUE: mem_en=1 (mem_we=latched we) for this cycle only; lat counter=1 -> WAIT.
//    WAIT:  count; when counter==MEM_LAT, capture mem_rdata into rdata_o (reads only)
//           -> ACK. For writes rdata_o holds its previous value.
//    ACK:   ack_o[winner]=1 for this cycle only -> IDLE (no direct ACK->ISSUE).
//  - Latency: req seen in IDLE at cycle 0 -> mem_en at 1 -> ack at MEM_LAT+2.
//    Throughput: one access per MEM_LAT+3 cycles under continuous requests.
//  - Priority: loader > data > fetch.
//    consec = number of consecutive grants to last-grant; resets to 1 when the winner changes.
//    If consec==MAX_CONSEC and any other req_i is high, last-grant is masked for that
//    arbitration. The counter saturates; idle cycles do not clear it.
//  - Handshake: requester holds req until ack and drops it on the edge after ack.
//    addr/we/wdata are sampled only in the IDLE grant cycle. If req drops mid-access,
//    the access still completes and ack still pulses.
//  - A request present but not granted waits; no ack and no side effect.
//  - Reset mid-access: next cycle IDLE, no ack, mem_en low. A memory write already
//    strobed stands.
// TESTING
//  1. MEM_LAT=1, fetch read addr 0x10, mem returns 0xA5 -> mem_en at c1, ack_o=3'b100
//     at c3, rdata_o=0xA5.
//  2. Loader write 0x3C to 0x20 -> mem_en & mem_we one cycle, mem_addr=0x20,
//     mem_wdata=0x3C, ack_o=3'b001, rdata_o unchanged.
//  3. req_i=3'b110 simultaneously -> data (ack 3'b010) served first, then fetch (3'b100).
//  4. Data and fetch held high continuously, MAX_CONSEC=4 -> 4 data acks, 1 fetch ack,
//     repeating.
//  5. rst asserted during WAIT (MEM_LAT=3) -> IDLE next cycle, no ack, all outputs 0;
//     a new request after rst is served normally.
//  6. Fetch drops req in WAIT -> ack_o=3'b100 still pulses once; the next request is
//     accepted in the IDLE cycle after ACK.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates three requesters (loader, data, fetch) onto one single-port memory.
// One access at a time: IDLE -> ISSUE -> WAIT -> ACK, with fixed read latency MEM_LAT.
module mem_arbiter #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned MAX_CONSEC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        req_i,
   input  logic [2:0]        we_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [ADDR_W-1:0] addr2_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic [DATA_W-1:0] wdata1_i,
   input  logic [DATA_W-1:0] wdata2_i,
   output logic [2:0]        ack_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              busy_o,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned       LatW    = $clog2(MEM_LAT + 1);
   localparam int unsigned       ConsW   = $clog2(MAX_CONSEC + 1);
   localparam logic [LatW-1:0]   LatLast = LatW'(MEM_LAT);
   localparam logic [ConsW-1:0]  ConsMax = ConsW'(MAX_CONSEC);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

   state_e            state_q, state_d;
   logic [LatW-1:0]   lat_q, lat_d;
   logic [ConsW-1:0]  consec_q, consec_d;
   logic [2:0]        last_q, last_d;
   logic [2:0]        grant_q, grant_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [2:0]        other_req;
   logic [2:0]        elig;
   logic [2:0]        win;

   // Fixed priority loader > data > fetch, with the last winner masked once it has
   // used up its consecutive-grant allowance and someone else is waiting.
   always_comb begin
      other_req = req_i & ~last_q;
      elig      = req_i;
      if (consec_q == ConsMax && other_req != 3'b000) begin
         elig = other_req;
      end
      win = 3'b000;
      if (elig[0]) begin
         win = 3'b001;
      end else if (elig[1]) begin
         win = 3'b010;
      end else if (elig[2]) begin
         win = 3'b100;
      end
   end

   always_comb begin
      state_d  = state_q;
      lat_d    = lat_q;
      consec_d = consec_q;
      last_d   = last_q;
      grant_d  = grant_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      unique case (state_q)
         StIdle: begin
            if (req_i != 3'b000) begin
               grant_d = win;
               last_d  = win;
               we_d    = |(we_i & win);
               if (win[0]) begin
                  addr_d  = addr0_i;
                  wdata_d = wdata0_i;
               end else if (win[1]) begin
                  addr_d  = addr1_i;
                  wdata_d = wdata1_i;
               end else begin
                  addr_d  = addr2_i;
                  wdata_d = wdata2_i;
               end
               if (win != last_q) begin
                  consec_d = ConsW'(1);
               end else if (consec_q != ConsMax) begin
                  consec_d = consec_q + ConsW'(1);
               end
               state_d = StIssue;
            end
         end
         StIssue: begin
            lat_d   = LatW'(1);
            state_d = StWait;
         end
         StWait: begin
            if (lat_q == LatLast) begin
               if (!we_q) begin
                  rdata_d = mem_rdata;
               end
               state_d = StAck;
            end else begin
               lat_d = lat_q + LatW'(1);
            end
         end
         StAck: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      mem_en    = (state_q == StIssue);
      mem_we    = (state_q == StIssue) && we_q;
      ack_o     = (state_q == StAck) ? grant_q : 3'b000;
      busy_o    = (state_q != StIdle);
      rdata_o   = rdata_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         lat_q    <= '0;
         consec_q <= '0;
         last_q   <= 3'b000;
         grant_q  <= 3'b000;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         lat_q    <= lat_d;
         consec_q <= consec_d;
         last_q   <= last_d;
         grant_q  <= grant_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed multi-cycle sequences, and a
// randomized run against a transaction-timing reference model.
module tb_mem_arbiter;

   localparam int L1   = 1;
   localparam int L3   = 3;
   localparam int MaxC = 4;

   typedef struct {
      logic [2:0] req;
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rd;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] req = 3'b000;
   logic [2:0] req3 = 3'b000;
   logic [2:0] we = 3'b000;
   logic [7:0] addr_a [3];
   logic [7:0] wdata_a [3];

   logic [2:0] ack1, ack3;
   logic [7:0] rdata1, rdata3, maddr1, maddr3, mwdata1, mwdata3, mrdata1, mrdata3;
   logic       busy1, busy3, en1, en3, mwe1, mwe3;

   logic [7:0] mem1 [256] = '{default: 8'h00};
   logic [7:0] mem3 [256] = '{default: 8'h00};
   logic [7:0] mem_ref [256] = '{default: 8'h00};
   logic [7:0] rd1 = 8'h00;
   logic [7:0] rd3 = 8'h00;
   int         cnt1 = 0;
   int         cnt3 = 0;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(L1), .MAX_CONSEC(MaxC)) u_dut1 (
      .clk      (clk),
      .rst      (rst),
      .req_i    (req),
      .we_i     (we),
      .addr0_i  (addr_a[0]),
      .addr1_i  (addr_a[1]),
      .addr2_i  (addr_a[2]),
      .wdata0_i (wdata_a[0]),
      .wdata1_i (wdata_a[1]),
      .wdata2_i (wdata_a[2]),
      .ack_o    (ack1),
      .rdata_o  (rdata1),
      .busy_o   (busy1),
      .mem_en   (en1),
      .mem_we   (mwe1),
      .mem_addr (maddr1),
      .mem_wdata(mwdata1),
      .mem_rdata(mrdata1)
   );

   mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(L3), .MAX_CONSEC(MaxC)) u_dut3 (
      .clk      (clk),
      .rst      (rst),
      .req_i    (req3),
      .we_i     (we),
      .addr0_i  (addr_a[0]),
      .addr1_i  (addr_a[1]),
      .addr2_i  (addr_a[2]),
      .wdata0_i (wdata_a[0]),
      .wdata1_i (wdata_a[1]),
      .wdata2_i (wdata_a[2]),
      .ack_o    (ack3),
      .rdata_o  (rdata3),
      .busy_o   (busy3),
      .mem_en   (en3),
      .mem_we   (mwe3),
      .mem_addr (maddr3),
      .mem_wdata(mwdata3),
      .mem_rdata(mrdata3)
   );

   // Memories drive valid read data only in the single cycle MEM_LAT after the
   // strobe, and the inverted word otherwise, so a mistimed capture is visible.
   always @(posedge clk) begin
      if (en1 && mwe1) mem1[maddr1] <= mwdata1;
      if (en1 && !mwe1) begin
         rd1  <= mem1[maddr1];
         cnt1 <= L1;
      end else if (cnt1 != 0) begin
         cnt1 <= cnt1 - 1;
      end
   end
   assign mrdata1 = (cnt1 == 1) ? rd1 : ~rd1;

   always @(posedge clk) begin
      if (en3 && mwe3) mem3[maddr3] <= mwdata3;
      if (en3 && !mwe3) begin
         rd3  <= mem3[maddr3];
         cnt3 <= L3;
      end else if (cnt3 != 0) begin
         cnt3 <= cnt3 - 1;
      end
   end
   assign mrdata3 = (cnt3 == 1) ? rd3 : ~rd3;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Drive one channel with the access; the other channels carry decoy values.
   task automatic set_chan(input int idx, input logic wr, input logic [7:0] a,
                           input logic [7:0] d);
      for (int k = 0; k < 3; k++) begin
         addr_a[k]  = (k == idx) ? a : ~a;
         wdata_a[k] = (k == idx) ? d : ~d;
         we[k]      = (k == idx) ? wr : ~wr;
      end
   endtask

   task automatic wait_ack(input bit on3, input int bound, output logic [2:0] a, output int n);
      a = 3'b000;
      n = 0;
      while (n < bound && a == 3'b000) begin
         tick();
         n++;
         a = on3 ? ack3 : ack1;
      end
   endtask

   vec_t       tbl [7];
   logic [2:0] a;
   int         n;
   int         idx;
   // reference model state
   int         t, grant_t, free_at, win, m_last, m_consec;
   bit         active, others;
   logic       g_we, exp_en, exp_busy;
   logic [7:0] g_addr, g_wdata, exp_rd;
   logic [2:0] exp_ack;

   initial begin
      tbl[0] = '{req: 3'b001, wr: 1'b1, addr: 8'h10, wdata: 8'hA5, exp_rd: 8'h00};
      tbl[1] = '{req: 3'b100, wr: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rd: 8'hA5};
      tbl[2] = '{req: 3'b001, wr: 1'b1, addr: 8'h20, wdata: 8'h3C, exp_rd: 8'hA5};
      tbl[3] = '{req: 3'b010, wr: 1'b0, addr: 8'h20, wdata: 8'h11, exp_rd: 8'h3C};
      tbl[4] = '{req: 3'b010, wr: 1'b1, addr: 8'hFF, wdata: 8'h99, exp_rd: 8'h3C};
      tbl[5] = '{req: 3'b100, wr: 1'b0, addr: 8'hFF, wdata: 8'h22, exp_rd: 8'h99};
      tbl[6] = '{req: 3'b001, wr: 1'b0, addr: 8'h00, wdata: 8'h33, exp_rd: 8'h00};
      set_chan(0, 1'b0, 8'h00, 8'h00);

      // reset state
      repeat (3) tick();
      chk("rst_ack", ack1, 3'b000);
      chk("rst_busy", busy1, 1'b0);
      chk("rst_en", en1, 1'b0);
      chk("rst_we", mwe1, 1'b0);
      chk("rst_rdata", rdata1, 8'h00);
      chk("rst_addr", maddr1, 8'h00);
      chk("rst_wdata", mwdata1, 8'h00);
      chk("rst_busy3", busy3, 1'b0);
      rst = 1'b0;
      tick();

      // single accesses, MEM_LAT=1
      for (int v = 0; v < 7; v++) begin
         idx = tbl[v].req[0] ? 0 : (tbl[v].req[1] ? 1 : 2);
         set_chan(idx, tbl[v].wr, tbl[v].addr, tbl[v].wdata);
         req = tbl[v].req;
         tick();
         chk("tbl_en", en1, 1'b1);
         chk("tbl_we", mwe1, tbl[v].wr);
         chk("tbl_addr", maddr1, tbl[v].addr);
         if (tbl[v].wr) chk("tbl_wdata", mwdata1, tbl[v].wdata);
         chk("tbl_busy", busy1, 1'b1);
         tick();
         chk("tbl_ack_early", ack1, 3'b000);
         chk("tbl_en_once", en1, 1'b0);
         tick();
         chk("tbl_ack", ack1, tbl[v].req);
         chk("tbl_rdata", rdata1, tbl[v].exp_rd);
         req = 3'b000;
         tick();
         chk("tbl_idle", busy1, 1'b0);
         chk("tbl_ack_once", ack1, 3'b000);
      end

      // simultaneous data+fetch: data first, fetch waits
      we = 3'b000;
      addr_a[1] = 8'h20;
      addr_a[2] = 8'h10;
      req = 3'b110;
      wait_ack(1'b0, 10, a, n);
      chk("t3_first", a, 3'b010);
      chk("t3_first_lat", n, L1 + 2);
      chk("t3_first_rdata", rdata1, 8'h3C);
      req = 3'b100;
      wait_ack(1'b0, 10, a, n);
      chk("t3_second", a, 3'b100);
      chk("t3_second_gap", n, L1 + 3);
      chk("t3_second_rdata", rdata1, 8'hA5);
      req = 3'b000;
      repeat (2) tick();

      // continuous data+fetch: four data grants then one fetch, repeating
      req = 3'b110;
      for (int k = 0; k < 10; k++) begin
         wait_ack(1'b0, 10, a, n);
         chk("t4_order", a, (k % 5 == 4) ? 3'b100 : 3'b010);
         chk("t4_gap", n, (k == 0) ? L1 + 2 : L1 + 3);
      end
      req = 3'b000;
      repeat (2) tick();

      // consec saturates with no competitor and survives idle cycles
      req = 3'b010;
      for (int k = 0; k < 6; k++) begin
         wait_ack(1'b0, 10, a, n);
         chk("sat_alone", a, 3'b010);
      end
      req = 3'b000;
      repeat (5) tick();
      req = 3'b110;
      wait_ack(1'b0, 10, a, n);
      chk("sat_masked", a, 3'b100);
      req = 3'b000;
      repeat (2) tick();

      // fetch drops req during WAIT; ack still pulses; next req taken right after ACK
      set_chan(2, 1'b0, 8'h20, 8'h00);
      req = 3'b100;
      tick();
      chk("t6_en", en1, 1'b1);
      tick();
      req = 3'b000;
      tick();
      chk("t6_ack", ack1, 3'b100);
      chk("t6_rdata", rdata1, 8'h3C);
      set_chan(1, 1'b0, 8'h10, 8'h00);
      req = 3'b010;
      tick();
      chk("t6_ack_once", ack1, 3'b000);
      chk("t6_idle", busy1, 1'b0);
      tick();
      chk("t6_next_en", en1, 1'b1);
      chk("t6_next_addr", maddr1, 8'h10);
      repeat (2) tick();
      chk("t6_next_ack", ack1, 3'b010);
      chk("t6_next_rdata", rdata1, 8'hA5);
      req = 3'b000;
      repeat (2) tick();

      // reset in WAIT, MEM_LAT=3
      set_chan(2, 1'b0, 8'h33, 8'h00);
      req3 = 3'b100;
      tick();
      chk("t5_en", en3, 1'b1);
      tick();
      tick();
      chk("t5_wait_busy", busy3, 1'b1);
      chk("t5_wait_ack", ack3, 3'b000);
      rst = 1'b1;
      req3 = 3'b000;
      tick();
      chk("t5_rst_ack", ack3, 3'b000);
      chk("t5_rst_busy", busy3, 1'b0);
      chk("t5_rst_en", en3, 1'b0);
      chk("t5_rst_rdata", rdata3, 8'h00);
      chk("t5_rst_addr", maddr3, 8'h00);
      rst = 1'b0;
      tick();
      chk("t5_no_late_ack", ack3, 3'b000);
      set_chan(0, 1'b1, 8'h33, 8'h77);
      req3 = 3'b001;
      wait_ack(1'b1, 12, a, n);
      chk("t5_wr_ack", a, 3'b001);
      chk("t5_wr_lat", n, L3 + 2);
      req3 = 3'b000;
      tick();
      set_chan(1, 1'b0, 8'h33, 8'h00);
      req3 = 3'b010;
      wait_ack(1'b1, 12, a, n);
      chk("t5_rd_ack", a, 3'b010);
      chk("t5_rd_lat", n, L3 + 2);
      chk("t5_rd_rdata", rdata3, 8'h77);
      req3 = 3'b000;
      tick();

      // randomized requesters vs. reference model (dut1 was reset above)
      t = 0; free_at = 0; active = 0; m_last = -1; m_consec = 0; win = 0;
      grant_t = 0; g_we = 0; g_addr = 0; g_wdata = 0; exp_rd = 8'h00;
      req = 3'b000;
      for (int c = 0; c < 1500; c++) begin
         tick();
         t++;
         exp_en   = active && (t == grant_t + 1);
         exp_ack  = (active && t == grant_t + L1 + 2) ? 3'(1 << win) : 3'b000;
         exp_busy = active && (t > grant_t) && (t <= grant_t + L1 + 2);
         chk("rnd_ack", ack1, exp_ack);
         chk("rnd_en", en1, exp_en);
         chk("rnd_busy", busy1, exp_busy);
         if (exp_en) begin
            chk("rnd_we", mwe1, g_we);
            chk("rnd_addr", maddr1, g_addr);
            if (g_we) chk("rnd_wdata", mwdata1, g_wdata);
         end
         if (exp_ack != 3'b000) begin
            chk("rnd_rdata", rdata1, exp_rd);
            active  = 0;
            free_at = t + 1;
         end
         for (int i = 0; i < 3; i++) begin
            if (ack1[i]) begin
               req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(3) == 0) begin
               req[i]     = 1'b1;
               we[i]      = 1'($urandom_range(1));
               addr_a[i]  = 8'h40 + 8'($urandom_range(15));
               wdata_a[i] = 8'($urandom);
            end
         end
         if (!active && t >= free_at && req != 3'b000) begin
            others = 0;
            for (int j = 0; j < 3; j++) if (req[j] && j != m_last) others = 1;
            win = -1;
            for (int j = 0; j < 3; j++) begin
               if (win < 0 && req[j] && !(m_consec == MaxC && others && j == m_last)) win = j;
            end
            if (win == m_last) m_consec = (m_consec < MaxC) ? m_consec + 1 : MaxC;
            else m_consec = 1;
            m_last  = win;
            active  = 1;
            grant_t = t;
            g_we    = we[win];
            g_addr  = addr_a[win];
            g_wdata = wdata_a[win];
            if (g_we) mem_ref[g_addr] = g_wdata;
            else exp_rd = mem_ref[g_addr];
         end
      end
      req = 3'b000;
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
